// File: rtl/thunderbird_lamp_sequencer.sv
// Thunderbird tail-lamp sequencer: synchronises the dashboard switches and paces
// left/right turn sweeps (A, AB, ABC, off) or a six-lamp hazard flash from a tick divider.
module thunderbird_lamp_sequencer #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic left_sw,
  input  logic right_sw,
  input  logic hazard_sw,
  output logic la,
  output logic lb,
  output logic lc,
  output logic ra,
  output logic rb,
  output logic rc,
  output logic busy
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StL1,
    StL2,
    StL3,
    StR1,
    StR2,
    StR3,
    StHaz
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      lamps_q, lamps_d;  // {la, lb, lc, ra, rb, rc}
  logic            busy_q;
  logic [2:0]      sync1_q, sync2_q;  // {hazard, left, right}

  logic hs, ls, rs, haz_req, tick;

  assign hs      = sync2_q[2];
  assign ls      = sync2_q[1];
  assign rs      = sync2_q[0];
  assign haz_req = hs | (ls & rs);
  assign tick    = (cnt_q == CntMax);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {hazard_sw, left_sw, right_sw};
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (haz_req)  state_d = StHaz;
          else if (ls)  state_d = StL1;
          else if (rs)  state_d = StR1;
        end
        StL1:    state_d = haz_req ? StHaz : StL2;
        StL2:    state_d = haz_req ? StHaz : StL3;
        StL3:    state_d = haz_req ? StHaz : StIdle;
        StR1:    state_d = haz_req ? StHaz : StR2;
        StR2:    state_d = haz_req ? StHaz : StR3;
        StR3:    state_d = haz_req ? StHaz : StIdle;
        StHaz:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Counter restarts on every state change; IDLE parks it at the tick value so a
  // fresh request is taken on the very next edge.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == StIdle) && tick) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    unique case (state_d)
      StIdle:  lamps_d = 6'b000_000;
      StL1:    lamps_d = 6'b100_000;
      StL2:    lamps_d = 6'b110_000;
      StL3:    lamps_d = 6'b111_000;
      StR1:    lamps_d = 6'b000_100;
      StR2:    lamps_d = 6'b000_110;
      StR3:    lamps_d = 6'b000_111;
      StHaz:   lamps_d = 6'b111_111;
      default: lamps_d = 6'b000_000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= CntMax;
      lamps_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lamps_q <= lamps_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign {la, lb, lc, ra, rb, rc} = lamps_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_thunderbird_lamp_sequencer.sv
// Bench for thunderbird_lamp_sequencer: per-edge vector tables checked through a
// scoreboard queue, plus hand-written reset sequences.
module tb_thunderbird_lamp_sequencer;

  logic clk = 1'b0;
  logic reset, left_sw, right_sw, hazard_sw;
  logic la, lb, lc, ra, rb, rc, busy;

  always #5 clk = ~clk;

  thunderbird_lamp_sequencer #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .left_sw  (left_sw),
    .right_sw (right_sw),
    .hazard_sw(hazard_sw),
    .la       (la),
    .lb       (lb),
    .lc       (lc),
    .ra       (ra),
    .rb       (rb),
    .rc       (rc),
    .busy     (busy)
  );

  typedef struct {
    string      name;
    logic       l;
    logic       r;
    logic       h;
    logic [5:0] lamps;
    logic       busy;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] lamps;
    logic       busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [5:0] exp_l, input logic exp_b);
    n_checks++;
    if (({la, lb, lc, ra, rb, rc} !== exp_l) || (busy !== exp_b)) begin
      n_fail++;
      $display("FAIL %s @%0t: lamps=%b busy=%b, expected lamps=%b busy=%b", name, $time,
               {la, lb, lc, ra, rb, rc}, busy, exp_l, exp_b);
    end
  endtask

  task automatic add(input string name, input int n, input logic l, input logic r,
                     input logic h, input logic [5:0] lamps, input logic b);
    vec_t v;
    v.name  = name;
    v.l     = l;
    v.r     = r;
    v.h     = h;
    v.lamps = lamps;
    v.busy  = b;
    repeat (n) vecs.push_back(v);
  endtask

  // Row k drives inputs before edge k and expects outputs just after edge k.
  task automatic run_vecs();
    exp_t e;
    exp_t got;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      left_sw   = vecs[i].l;
      right_sw  = vecs[i].r;
      hazard_sw = vecs[i].h;
      e.name  = $sformatf("%s[%0d]", vecs[i].name, i);
      e.lamps = vecs[i].lamps;
      e.busy  = vecs[i].busy;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check(got.name, got.lamps, got.busy);
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    left_sw   = 1'b1;
    hazard_sw = 1'b1;
    #1;
    check("reset_async", 6'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {hazard_sw, left_sw, right_sw} = 3'(i + 3);
      @(posedge clk);
      #1;
      check("reset_hold", 6'b0, 1'b0);
    end
    @(negedge clk);
    {hazard_sw, left_sw, right_sw} = 3'b000;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; left_sw = 1'b0; right_sw = 1'b0; hazard_sw = 1'b0;

    // Reset with switches toggling, then nothing lights.
    do_reset();
    add("s1_idle", 12, 0, 0, 0, 6'b000_000, 0);
    run_vecs();

    // Left held.
    do_reset();
    add("s2_wait", 2, 1, 0, 0, 6'b000_000, 0);
    add("s2_a",    4, 1, 0, 0, 6'b100_000, 1);
    add("s2_ab",   4, 1, 0, 0, 6'b110_000, 1);
    add("s2_abc",  4, 1, 0, 0, 6'b111_000, 1);
    add("s2_off",  4, 1, 0, 0, 6'b000_000, 0);
    add("s2_a2",   4, 1, 0, 0, 6'b100_000, 1);
    run_vecs();

    // Right held.
    do_reset();
    add("s3r_wait", 2, 0, 1, 0, 6'b000_000, 0);
    add("s3r_a",    4, 0, 1, 0, 6'b000_100, 1);
    add("s3r_ab",   4, 0, 1, 0, 6'b000_110, 1);
    add("s3r_abc",  4, 0, 1, 0, 6'b000_111, 1);
    add("s3r_off",  4, 0, 1, 0, 6'b000_000, 0);
    add("s3r_a2",   2, 0, 1, 0, 6'b000_100, 1);
    run_vecs();

    // Hazard switch held.
    do_reset();
    add("s3h_wait", 2, 0, 0, 1, 6'b000_000, 0);
    add("s3h_on",   4, 0, 0, 1, 6'b111_111, 1);
    add("s3h_off",  4, 0, 0, 1, 6'b000_000, 0);
    add("s3h_on2",  4, 0, 0, 1, 6'b111_111, 1);
    add("s3h_off2", 2, 0, 0, 1, 6'b000_000, 0);
    run_vecs();

    // Left and right together act as hazard.
    do_reset();
    add("s3lr_wait", 2, 1, 1, 0, 6'b000_000, 0);
    add("s3lr_on",   4, 1, 1, 0, 6'b111_111, 1);
    add("s3lr_off",  4, 1, 1, 0, 6'b000_000, 0);
    add("s3lr_on2",  4, 1, 1, 0, 6'b111_111, 1);
    run_vecs();

    // Hazard raised during L2: no L3 step, straight to HAZ; hazard wins over left.
    do_reset();
    add("s4_wait", 2, 1, 0, 0, 6'b000_000, 0);
    add("s4_a",    4, 1, 0, 0, 6'b100_000, 1);
    add("s4_ab",   4, 1, 0, 1, 6'b110_000, 1);
    add("s4_haz",  4, 1, 0, 1, 6'b111_111, 1);
    add("s4_off",  4, 1, 0, 1, 6'b000_000, 0);
    add("s4_haz2", 4, 1, 0, 1, 6'b111_111, 1);
    run_vecs();

    // Left pulsed for 3 cycles: one full sweep, no repeat.
    do_reset();
    add("s5_pulse", 2, 1, 0, 0, 6'b000_000, 0);
    add("s5_a0",    1, 1, 0, 0, 6'b100_000, 1);
    add("s5_a",     3, 0, 0, 0, 6'b100_000, 1);
    add("s5_ab",    4, 0, 0, 0, 6'b110_000, 1);
    add("s5_abc",   4, 0, 0, 0, 6'b111_000, 1);
    add("s5_idle",  8, 0, 0, 0, 6'b000_000, 0);
    run_vecs();

    // Async reset mid-L3, then restart with left still held.
    do_reset();
    add("s6_wait", 2, 1, 0, 0, 6'b000_000, 0);
    add("s6_a",    4, 1, 0, 0, 6'b100_000, 1);
    add("s6_ab",   4, 1, 0, 0, 6'b110_000, 1);
    add("s6_abc",  2, 1, 0, 0, 6'b111_000, 1);
    run_vecs();
    #2;
    reset = 1'b0;
    #1;
    check("s6_async_drop", 6'b000_000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("s6_rel_edge0", 6'b000_000, 1'b0);
    add("s6r_wait", 1, 1, 0, 0, 6'b000_000, 0);
    add("s6r_a",    4, 1, 0, 0, 6'b100_000, 1);
    add("s6r_ab",   4, 1, 0, 0, 6'b110_000, 1);
    run_vecs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
